i2c_master_axil: RTL and testbench

AXI-Lite controlled single-byte I2C master: the initiator counterpart of the team's AXI-Lite I2C slave wrapper.
- Software programs target address, direction and TX byte, then pulses GO.
- The block generates START, address+R/W, one data byte with ACK handling, and STOP on open-drain SCL/SDA.
- Status is reported back over the same register map.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_master_core.sv | 118 +++++++++++
 rtl/i2c_master_axil.sv | 143 ++++++++++++++
 tb/tb_i2c_master_axil.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encoding, register offsets and status bit positions for the AXI-Lite I2C master
package i2c_pkg;
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_START    = 4'd1;
    localparam logic [3:0] ST_ADDR     = 4'd2;
    localparam logic [3:0] ST_ADDR_ACK = 4'd3;
    localparam logic [3:0] ST_WR_DATA  = 4'd4;
    localparam logic [3:0] ST_WR_ACK   = 4'd5;
    localparam logic [3:0] ST_RD_DATA  = 4'd6;
    localparam logic [3:0] ST_RD_NACK  = 4'd7;
    localparam logic [3:0] ST_STOP     = 4'd8;
    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_ADDR    = 3'd1;
    localparam logic [2:0] REG_TXDATA  = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_RXDATA  = 3'd4;
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_NACK = 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/i2c_master_core.sv
// i2c_master_core: quarter-tick bit timing, transfer FSM and shift registers (I2C_CLK_STRETCH_EN enables SCL stretching)
module i2c_master_core
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       S_AXI_ACLK,
    input  logic       slave_rst,
    input  logic       go,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] txdata,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic [7:0] rxdata
);
    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

    logic [3:0]  state;
    logic [1:0]  q;
    logic [2:0]  bitn;
    logic [7:0]  sh;
    logic [7:0]  tx_r;
    logic [15:0] cnt;
    logic        rw_r;
    logic        ack_bit;
    logic        hold;
    logic        tick;

`ifdef I2C_CLK_STRETCH_EN
    assign hold = (q == 2'd1 || q == 2'd2) && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold = 1'b0;
`endif

    assign tick = state != ST_IDLE && !hold && cnt == DIV_M1;
    assign busy = state != ST_IDLE;
    assign done = tick && q == 2'd3 && state == ST_STOP;
    assign nack = tick && q == 2'd3 && ack_bit && (state == ST_ADDR_ACK || state == ST_WR_ACK);
    assign scl_oe = state != ST_IDLE && state != ST_START &&
                    (state == ST_STOP ? q == 2'd0 : (q == 2'd0 || q == 2'd3));
    assign sda_oe = state == ST_START || (state == ST_STOP && q != 2'd3) ||
                    ((state == ST_ADDR || state == ST_WR_DATA) && !sh[7]);

    // Quarter-period counter; parked at zero while idle so every transfer starts on a full quarter
    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst)
            cnt <= '0;
        else if (state == ST_IDLE || tick)
            cnt <= '0;
        else if (!hold)
            cnt <= cnt + 16'd1;
    end

    // Transfer sequencer: SDA sampled at the end of q2, state advances at the end of q3
    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst) begin
            state   <= ST_IDLE;
            q       <= '0;
            bitn    <= '0;
            sh      <= '0;
            tx_r    <= '0;
            rw_r    <= 1'b0;
            ack_bit <= 1'b0;
            rxdata  <= '0;
        end else if (state == ST_IDLE) begin
            if (go) begin
                state <= ST_START;
                sh    <= {addr, rw};
                rw_r  <= rw;
                tx_r  <= txdata;
                q     <= '0;
                bitn  <= '0;
            end
        end else if (tick) begin
            q <= q + 2'd1;
            if (q == 2'd2) begin
                ack_bit <= sda_i;
                if (state == ST_RD_DATA)
                    sh <= {sh[6:0], sda_i};
            end
            if (state == ST_START && q == 2'd1) begin
                state <= ST_ADDR;
                q     <= '0;
            end
            if (q == 2'd3) begin
                case (state)
                    ST_ADDR, ST_WR_DATA: begin
                        sh   <= {sh[6:0], 1'b0};
                        bitn <= bitn + 3'd1;
                        if (bitn == 3'd7)
                            state <= state == ST_ADDR ? ST_ADDR_ACK : ST_WR_ACK;
                    end
                    ST_ADDR_ACK: begin
                        sh    <= tx_r;
                        state <= ack_bit ? ST_STOP : rw_r ? ST_RD_DATA : ST_WR_DATA;
                    end
                    ST_RD_DATA: begin
                        bitn <= bitn + 3'd1;
                        if (bitn == 3'd7) begin
                            state  <= ST_RD_NACK;
                            rxdata <= sh;
                        end
                    end
                    ST_WR_ACK, ST_RD_NACK: state <= ST_STOP;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/i2c_master_axil.sv
// i2c_master_axil: AXI-Lite register file around a single-byte I2C master core (I2C_CLK_STRETCH_EN enables SCL stretching)
module i2c_master_axil
    import i2c_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int CLK_DIV            = 125
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            slave_rst,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            scl_i,
    output logic                            scl_oe,
    input  logic                            sda_i,
    output logic                            sda_oe,
    output logic                            irq
);
    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic          aw_rdy;
    logic          ar_rdy;
    logic          b_vld;
    logic          r_vld;
    logic [DW-1:0] r_data;
    logic [DW-1:0] rd_mux;
    logic [2:0]    wr_idx;
    logic [2:0]    rd_idx;
    logic          wr_en;
    logic          go;
    logic          clr;
    logic          st_wr;
    logic          rw_r;
    logic          ie_r;
    logic [6:0]    addr_r;
    logic [7:0]    tx_r;
    logic          done_r;
    logic          nack_r;
    logic          busy;
    logic          core_done;
    logic          core_nack;
    logic [7:0]    rx;
    logic          unused_bits;

    assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB, S_AXI_WDATA[DW-1:8]};

    assign S_AXI_AWREADY = aw_rdy;
    assign S_AXI_WREADY  = aw_rdy;
    assign S_AXI_BVALID  = b_vld;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = ar_rdy;
    assign S_AXI_RVALID  = r_vld;
    assign S_AXI_RDATA   = r_data;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign irq           = done_r & ie_r;

    assign wr_idx = S_AXI_AWADDR[4:2];
    assign rd_idx = S_AXI_ARADDR[4:2];
    assign wr_en  = aw_rdy;
    assign go     = wr_en && wr_idx == REG_CTRL && S_AXI_WDATA[0];
    assign clr    = go && !busy;
    assign st_wr  = wr_en && wr_idx == REG_STATUS;

    assign rd_mux = rd_idx == REG_CTRL   ? DW'({ie_r, rw_r, 1'b0}) :
                    rd_idx == REG_ADDR   ? DW'(addr_r) :
                    rd_idx == REG_TXDATA ? DW'(tx_r) :
                    rd_idx == REG_STATUS ? DW'({nack_r, done_r, busy}) :
                    rd_idx == REG_RXDATA ? DW'(rx) : '0;

    // AXI-Lite handshakes: one-cycle ready pulses, responses held until accepted
    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst) begin
            aw_rdy <= 1'b0;
            b_vld  <= 1'b0;
            ar_rdy <= 1'b0;
            r_vld  <= 1'b0;
            r_data <= '0;
        end else begin
            aw_rdy <= !aw_rdy && S_AXI_AWVALID && S_AXI_WVALID && !b_vld;
            b_vld  <= aw_rdy ? 1'b1 : S_AXI_BREADY ? 1'b0 : b_vld;
            ar_rdy <= !ar_rdy && S_AXI_ARVALID && !r_vld;
            r_vld  <= ar_rdy ? 1'b1 : S_AXI_RREADY ? 1'b0 : r_vld;
            if (ar_rdy)
                r_data <= rd_mux;
        end
    end

    // Register file; a hardware DONE/NACK set beats a simultaneous software clear
    always_ff @(posedge S_AXI_ACLK or posedge slave_rst) begin
        if (slave_rst) begin
            rw_r   <= 1'b0;
            ie_r   <= 1'b0;
            addr_r <= '0;
            tx_r   <= '0;
            done_r <= 1'b0;
            nack_r <= 1'b0;
        end else begin
            if (wr_en && wr_idx == REG_CTRL)
                {ie_r, rw_r} <= S_AXI_WDATA[2:1];
            if (wr_en && wr_idx == REG_ADDR)
                addr_r <= S_AXI_WDATA[6:0];
            if (wr_en && wr_idx == REG_TXDATA)
                tx_r <= S_AXI_WDATA[7:0];
            done_r <= !clr && (core_done || (done_r && !(st_wr && S_AXI_WDATA[STAT_DONE])));
            nack_r <= !clr && (core_nack || (nack_r && !(st_wr && S_AXI_WDATA[STAT_NACK])));
        end
    end

    // The GO write carries RW in the same word, so the core snapshots it straight from WDATA
    i2c_master_core #(
        .CLK_DIV(CLK_DIV)
    ) u_core (
        .S_AXI_ACLK(S_AXI_ACLK),
        .slave_rst (slave_rst),
        .go        (go),
        .rw        (S_AXI_WDATA[1]),
        .addr      (addr_r),
        .txdata    (tx_r),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .done      (core_done),
        .nack      (core_nack),
        .rxdata    (rx)
    );
endmodule

// File: tb/tb_i2c_master_axil.sv
// tb_i2c_master_axil: directed AXI-Lite stimulus with a behavioural I2C slave at address 0x50
module tb_i2c_master_axil;
    logic        clk = 1'b0;
    logic        slave_rst = 1'b1;
    logic [4:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [4:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        scl_oe;
    logic        sda_oe;
    logic        irq;
    logic        scl_line;
    logic        sda_line;
    logic        stretch_low = 1'b0;
    logic        slv_sda_low = 1'b0;
    logic        stretch_en = 1'b0;

    int assert_cnt = 0;
    int fail_cnt = 0;

    int          start_cnt = 0;
    int          stop_cnt = 0;
    int          bit_n = 0;
    int          byte_n = 0;
    int          stretch_cnt = 0;
    int          low_cnt = 0;
    int          ack_low = 0;
    logic [7:0]  sh = '0;
    logic [7:0]  bytes [0:3];
    logic        matched = 1'b0;
    logic        mack = 1'b0;
    logic        scl_p = 1'b1;
    logic        sda_p = 1'b1;
    logic [7:0]  slv_tx = 8'h3C;

    localparam logic [6:0] SLV = 7'h50;

    always #5 clk = ~clk;

    assign scl_line = !(scl_oe || stretch_low);
    assign sda_line = !(sda_oe || slv_sda_low);

    i2c_master_axil #(
        .CLK_DIV(4)
    ) dut (
        .S_AXI_ACLK   (clk),
        .slave_rst    (slave_rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .scl_i        (scl_line),
        .scl_oe       (scl_oe),
        .sda_i        (sda_line),
        .sda_oe       (sda_oe),
        .irq          (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One sample of the bus per falling clock edge: START/STOP, SCL edges, ACK and data driving
    task automatic slave_step();
        logic s;
        logic d;
        s = scl_line;
        d = sda_line;
        if (!s)
            low_cnt++;
        if (scl_p && s && sda_p && !d) begin
            start_cnt++;
            bit_n = 0;
            byte_n = 0;
            sh = '0;
            matched = 1'b0;
            slv_sda_low = 1'b0;
        end else if (scl_p && s && !sda_p && d) begin
            stop_cnt++;
            slv_sda_low = 1'b0;
        end else if (!scl_p && s) begin
            if (bit_n == 8 && byte_n == 0)
                ack_low = low_cnt;
            if (bit_n < 8) begin
                sh = {sh[6:0], d};
                bit_n++;
                if (bit_n == 8) begin
                    if (byte_n < 4)
                        bytes[byte_n] = sh;
                    if (byte_n == 0)
                        matched = sh[7:1] == SLV;
                end
            end else begin
                mack = d;
                bit_n = 0;
                byte_n++;
            end
        end else if (scl_p && !s) begin
            low_cnt = 1;
            if (bit_n == 8) begin
                slv_sda_low = matched && (byte_n == 0 || !bytes[0][0]);
                if (stretch_en && byte_n == 0)
                    stretch_cnt = 50;
            end else if (matched && bytes[0][0] && byte_n == 1)
                slv_sda_low = !slv_tx[7 - bit_n];
            else
                slv_sda_low = 1'b0;
        end
        if (stretch_cnt != 0)
            stretch_cnt--;
        stretch_low = stretch_cnt != 0;
        scl_p = s;
        sda_p = d;
    endtask

    initial forever begin
        @(negedge clk);
        slave_step();
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
        int n;
        awaddr = a;
        wdata = d;
        awvalid = 1'b1;
        wvalid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!awready && n < 20);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        check("bvalid", {31'b0, bvalid}, 32'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!arready && n < 20);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        d = rvalid ? rdata : 32'hDEAD_BEEF;
        r = rvalid ? rresp : 2'b11;
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        logic [1:0] r;
        int n;
        n = 0;
        do begin
            axi_read(5'h0C, st, r);
            n++;
        end while (st[0] && n < 500);
        check("idle_timeout", {31'b0, st[0]}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int s0;
        int p0;
        int n;
        #12;
        check("rst_awready", {31'b0, awready}, 32'h0);
        check("rst_bvalid", {31'b0, bvalid}, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_scl_oe", {31'b0, scl_oe}, 32'h0);
        check("rst_sda_oe", {31'b0, sda_oe}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1;
        slave_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        axi_read(5'h0C, d, r);
        check("rst_status", d, 32'h0);

        s0 = start_cnt;
        p0 = stop_cnt;
        axi_write(5'h04, 32'h50);
        axi_write(5'h08, 32'hA5);
        axi_write(5'h00, 32'h1);
        axi_read(5'h0C, d, r);
        check("wr_status_busy", d, 32'h1);
        wait_idle(d);
        check("wr_status_done", d, 32'h2);
        check("wr_addr_byte", {24'b0, bytes[0]}, 32'hA0);
        check("wr_data_byte", {24'b0, bytes[1]}, 32'hA5);
        check("wr_byte_count", byte_n, 2);
        check("wr_starts", start_cnt - s0, 1);
        check("wr_stops", stop_cnt - p0, 1);
        check("wr_irq", {31'b0, irq}, 32'h0);
        check("wr_lines_idle", {30'b0, scl_oe, sda_oe}, 32'h0);

        axi_write(5'h00, 32'h7);
        wait_idle(d);
        check("rd_status", d, 32'h2);
        check("rd_addr_byte", {24'b0, bytes[0]}, 32'hA1);
        check("rd_master_nack", {31'b0, mack}, 32'h1);
        axi_read(5'h10, d, r);
        check("rd_rxdata", d, 32'h3C);
        check("rd_irq", {31'b0, irq}, 32'h1);
        axi_read(5'h00, d, r);
        check("rd_ctrl_readback", d, 32'h6);

        p0 = stop_cnt;
        axi_write(5'h04, 32'h22);
        axi_write(5'h00, 32'h1);
        wait_idle(d);
        check("nack_status", d, 32'h6);
        check("nack_addr_byte", {24'b0, bytes[0]}, 32'h44);
        check("nack_byte_count", byte_n, 1);
        check("nack_stops", stop_cnt - p0, 1);
        check("nack_irq", {31'b0, irq}, 32'h0);
        axi_write(5'h0C, 32'h6);
        axi_read(5'h0C, d, r);
        check("w1c_status", d, 32'h0);

        s0 = start_cnt;
        axi_write(5'h04, 32'h50);
        axi_write(5'h08, 32'h5A);
        axi_write(5'h00, 32'h1);
        axi_write(5'h08, 32'hFF);
        axi_write(5'h00, 32'h1);
        wait_idle(d);
        check("gobusy_status", d, 32'h2);
        check("gobusy_starts", start_cnt - s0, 1);
        check("gobusy_snapshot", {24'b0, bytes[1]}, 32'h5A);
        axi_read(5'h08, d, r);
        check("txdata_readback", d, 32'hFF);
        axi_read(5'h14, d, r);
        check("unmapped_data", d, 32'h0);
        check("unmapped_resp", {30'b0, r}, 32'h0);

`ifdef I2C_CLK_STRETCH_EN
        stretch_en = 1'b1;
        axi_write(5'h08, 32'h96);
        axi_write(5'h00, 32'h1);
        wait_idle(d);
        stretch_en = 1'b0;
        check("stretch_status", d, 32'h2);
        check("stretch_data", {24'b0, bytes[1]}, 32'h96);
        check("stretch_low_len", {31'b0, ack_low >= 50}, 32'h1);
`endif

        axi_write(5'h00, 32'h1);
        repeat (60) @(posedge clk);
        #1;
        araddr = 5'h0C;
        arvalid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rvalid && n < 20);
        check("midrst_rvalid_before", {31'b0, rvalid}, 32'h1);
        check("midrst_driven_before", {31'b0, scl_oe | sda_oe}, 32'h1);
        #2;
        slave_rst = 1'b1;
        #1;
        check("midrst_rvalid", {31'b0, rvalid}, 32'h0);
        check("midrst_scl_oe", {31'b0, scl_oe}, 32'h0);
        check("midrst_sda_oe", {31'b0, sda_oe}, 32'h0);
        check("midrst_irq", {31'b0, irq}, 32'h0);
        arvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        slave_rst = 1'b0;
        @(posedge clk);
        #1;
        axi_read(5'h0C, d, r);
        check("midrst_status", d, 32'h0);
        axi_read(5'h04, d, r);
        check("midrst_addr", d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
